// File: rtl/sw_mem_cmd_ctrl.sv
// sw_mem_cmd_ctrl: turns the static software registers mem_cmd / mem_addr /
// mem_data_write into single tagged memory transactions on a request/grant
// port, with a per-phase timeout, and reports results through mem_status
// and mem_data_read.
module sw_mem_cmd_ctrl #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           mem_cmd,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_write,
  output logic [DATA_WIDTH-1:0] mem_data_read,
  output logic [31:0]           mem_status,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_gnt,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RD  = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  // Last counter value before an abort; the counter starts at 0 on phase entry.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [7:0]            last_tag_q, last_tag_d;
  logic [7:0]            to_cnt_q, to_cnt_d;
  logic                  m_req_q, m_req_d;
  logic                  m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]            fin_tag_q, fin_tag_d;
  logic [15:0]           count_q, count_d;
  logic                  addr_err_q, addr_err_d;
  logic                  timeout_q, timeout_d;
  logic                  bad_op_q, bad_op_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [1:0] cmd_op;
  logic [7:0] cmd_tag;
  logic       cmd_new;
  logic       addr_bad;
  logic       unused_cmd_bits;

  assign cmd_op          = mem_cmd[1:0];
  assign cmd_tag         = mem_cmd[31:24];
  assign cmd_new         = (cmd_op != 2'b00) && (cmd_tag != last_tag_q);
  assign addr_bad        = (mem_addr >> ADDR_WIDTH) != 32'd0;
  assign unused_cmd_bits = ^mem_cmd[23:2];

  // Next-state and register update logic for the command sequencer.
  always_comb begin
    state_d    = state_q;
    last_tag_d = last_tag_q;
    to_cnt_d   = to_cnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    rdata_d    = rdata_q;
    fin_tag_d  = fin_tag_q;
    count_d    = count_q;
    addr_err_d = addr_err_q;
    timeout_d  = timeout_q;
    bad_op_d   = bad_op_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      IDLE: begin
        if (cmd_new) begin
          last_tag_d = cmd_tag;
          addr_err_d = 1'b0;
          timeout_d  = 1'b0;
          bad_op_d   = 1'b0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          if (cmd_op == 2'b11) begin
            bad_op_d  = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            fin_tag_d = cmd_tag;
          end else if (addr_bad) begin
            addr_err_d = 1'b1;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            fin_tag_d  = cmd_tag;
          end else begin
            state_d   = REQ;
            m_req_d   = 1'b1;
            m_we_d    = (cmd_op == 2'b10);
            m_addr_d  = mem_addr[ADDR_WIDTH-1:0];
            m_wdata_d = mem_data_write;
            to_cnt_d  = 8'd0;
          end
        end
      end

      REQ: begin
        // A grant in the final allowed cycle still counts as success.
        if (m_gnt) begin
          m_req_d  = 1'b0;
          to_cnt_d = 8'd0;
          state_d  = m_we_q ? COMPLETE : WAIT_RD;
        end else if (to_cnt_q == TO_LAST) begin
          m_req_d   = 1'b0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          fin_tag_d = last_tag_q;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end

      WAIT_RD: begin
        if (m_rvalid) begin
          rdata_d = m_rdata;
          state_d = COMPLETE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          fin_tag_d = last_tag_q;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end

      COMPLETE: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        fin_tag_d = last_tag_q;
        count_d   = count_q + 16'd1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; async reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_tag_q <= 8'd0;
      to_cnt_q   <= 8'd0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      rdata_q    <= '0;
      fin_tag_q  <= 8'd0;
      count_q    <= 16'd0;
      addr_err_q <= 1'b0;
      timeout_q  <= 1'b0;
      bad_op_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_tag_q <= last_tag_d;
      to_cnt_q   <= to_cnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      rdata_q    <= rdata_d;
      fin_tag_q  <= fin_tag_d;
      count_q    <= count_d;
      addr_err_q <= addr_err_d;
      timeout_q  <= timeout_d;
      bad_op_q   <= bad_op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign m_req         = m_req_q;
  assign m_we          = m_we_q;
  assign m_addr        = m_addr_q;
  assign m_wdata       = m_wdata_q;
  assign mem_data_read = rdata_q;
  assign mem_status    = {fin_tag_q, count_q, 3'b000,
                          addr_err_q, timeout_q, bad_op_q, busy_q, done_q};

endmodule

// File: tb/tb_sw_mem_cmd_ctrl.sv
// Testbench for sw_mem_cmd_ctrl: directed scenarios plus randomized commands
// checked against a transaction-level model of the software register contract.
module tb_sw_mem_cmd_ctrl;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_cmd = '0, mem_addr = '0, mem_data_write = '0;
  logic [31:0] mem_data_read, mem_status;
  logic        m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  int pass_cnt = 0, total_cnt = 0;

  // memory emulator controls and observation counters
  bit          gnt_en = 1'b1;
  bit          noise_en = 1'b0;
  int          gnt_delay = 0;
  int          rv_delay = 0;
  int          wait_cnt = 0;
  bit          rv_pending = 1'b0;
  int          rv_cnt = 0;
  logic [AW-1:0] rv_addr = '0;
  logic [31:0] mem_arr [1024];
  int          gnt_count = 0, wr_count = 0, req_cycles = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  // reference model state
  logic [31:0] model_mem [1024];
  logic [7:0]  exp_fin = 8'd0, m_last_tag = 8'd0;
  logic [15:0] exp_count = 16'd0;
  logic [4:0]  exp_bits = 5'd0;
  logic [31:0] exp_rdata = '0;

  sw_mem_cmd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_data_write(mem_data_write),
    .mem_data_read(mem_data_read), .mem_status(mem_status),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // memory emulator: grants after gnt_delay cycles, returns read data rv_delay cycles later
  initial begin
    forever begin
      @(negedge clk);
      m_gnt = 1'b0;
      m_rvalid = 1'b0;
      m_rdata = $urandom;
      if (!reset) begin
        rv_pending = 1'b0;
        wait_cnt = 0;
      end else begin
        if (rv_pending) begin
          if (rv_cnt == 0) begin
            m_rvalid = 1'b1;
            m_rdata = mem_arr[rv_addr];
            rv_pending = 1'b0;
          end else begin
            rv_cnt--;
          end
        end
        if (m_req) begin
          req_cycles++;
          if (gnt_en && wait_cnt >= gnt_delay) begin
            m_gnt = 1'b1;
            gnt_count++;
            wait_cnt = 0;
            if (m_we) begin
              mem_arr[m_addr] = m_wdata;
              wr_count++;
              last_wr_addr = m_addr;
              last_wr_data = m_wdata;
            end else if (rv_delay >= 0) begin
              rv_pending = 1'b1;
              rv_cnt = rv_delay;
              rv_addr = m_addr;
            end
          end else begin
            wait_cnt++;
            if (noise_en && ($urandom & 1) != 0) m_rvalid = 1'b1;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_addr = addr;
    mem_data_write = data;
    mem_cmd = cmd;
  endtask

  task automatic wait_done(input logic [7:0] tag, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_status[31:24] == tag && mem_status[0] && !mem_status[1]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (mem_status !== 32'h0) $display("FAIL reset_status got=%h exp=%h", mem_status, 32'h0); else pass_cnt++;
    total_cnt++; if (mem_data_read !== 32'h0) $display("FAIL reset_rdata got=%h exp=%h", mem_data_read, 32'h0); else pass_cnt++;
    total_cnt++; if ({m_req, m_we} !== 2'b00) $display("FAIL reset_req_we got=%b exp=00", {m_req, m_we}); else pass_cnt++;
    total_cnt++; if ({m_addr, m_wdata} !== 42'h0) $display("FAIL reset_addr_wdata got=%h exp=0", {m_addr, m_wdata}); else pass_cnt++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    int wc0, rc0; bit ok;
    gnt_en = 1'b1; gnt_delay = 2; rv_delay = 0; noise_en = 1'b0;
    wc0 = wr_count; rc0 = req_cycles;
    issue(32'h01000002, 32'h5, 32'hDEADBEEF);
    wait_done(8'h01, 50, ok);
    total_cnt++; if (!ok) $display("FAIL wr_done got=%0d exp=1", ok); else pass_cnt++;
    total_cnt++; if (wr_count - wc0 != 1) $display("FAIL wr_pulses got=%0d exp=1", wr_count - wc0); else pass_cnt++;
    total_cnt++; if ({last_wr_addr, last_wr_data} !== {10'd5, 32'hDEADBEEF})
      $display("FAIL wr_addr_data got=%h/%h exp=5/deadbeef", last_wr_addr, last_wr_data); else pass_cnt++;
    total_cnt++; if (req_cycles - rc0 != 3) $display("FAIL wr_req_cycles got=%0d exp=3", req_cycles - rc0); else pass_cnt++;
    total_cnt++; if (mem_status !== 32'h01000101) $display("FAIL wr_status got=%h exp=%h", mem_status, 32'h01000101); else pass_cnt++;
    issue(32'h02000001, 32'h5, 32'h0);
    wait_done(8'h02, 50, ok);
    total_cnt++; if (!ok) $display("FAIL rd_done got=%0d exp=1", ok); else pass_cnt++;
    total_cnt++; if (mem_data_read !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", mem_data_read); else pass_cnt++;
    total_cnt++; if (mem_status !== 32'h02000201) $display("FAIL rd_status got=%h exp=%h", mem_status, 32'h02000201); else pass_cnt++;
    model_mem[5] = 32'hDEADBEEF;
    exp_fin = 8'h02; m_last_tag = 8'h02; exp_count = 16'd2; exp_bits = 5'h01; exp_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_same_tag();
    int rc0;
    rc0 = req_cycles;
    issue(32'h02000001, 32'h5, 32'h0);
    repeat (6) @(negedge clk);
    issue(32'h02000002, 32'h6, 32'h1111);
    repeat (6) @(negedge clk);
    total_cnt++; if (req_cycles != rc0) $display("FAIL same_tag_req got=%0d exp=%0d", req_cycles, rc0); else pass_cnt++;
    total_cnt++; if (mem_status !== 32'h02000201) $display("FAIL same_tag_status got=%h exp=%h", mem_status, 32'h02000201); else pass_cnt++;
  endtask

  task automatic test_errors();
    int rc0;
    rc0 = req_cycles;
    issue(32'h03000003, 32'h5, 32'h0);
    repeat (4) @(negedge clk);
    total_cnt++; if (mem_status !== 32'h03000205) $display("FAIL bad_op_status got=%h exp=%h", mem_status, 32'h03000205); else pass_cnt++;
    issue(32'h04000001, 32'h400, 32'h0);
    repeat (4) @(negedge clk);
    total_cnt++; if (mem_status !== 32'h04000211) $display("FAIL addr_err_status got=%h exp=%h", mem_status, 32'h04000211); else pass_cnt++;
    total_cnt++; if (req_cycles != rc0) $display("FAIL err_no_req got=%0d exp=%0d", req_cycles, rc0); else pass_cnt++;
    exp_fin = 8'h04; m_last_tag = 8'h04; exp_bits = 5'h11;
  endtask

  task automatic test_timeout();
    int rc0; bit ok;
    gnt_en = 1'b0;
    rc0 = req_cycles;
    issue(32'h0A000001, 32'h3, 32'h0);
    wait_done(8'h0A, 400, ok);
    gnt_en = 1'b1;
    total_cnt++; if (!ok) $display("FAIL to_done got=%0d exp=1", ok); else pass_cnt++;
    total_cnt++; if (req_cycles - rc0 != 255) $display("FAIL to_req_cycles got=%0d exp=255", req_cycles - rc0); else pass_cnt++;
    total_cnt++; if (mem_status !== 32'h0A000209) $display("FAIL to_status got=%h exp=%h", mem_status, 32'h0A000209); else pass_cnt++;
    total_cnt++; if (mem_data_read !== 32'hDEADBEEF) $display("FAIL to_rdata got=%h exp=deadbeef", mem_data_read); else pass_cnt++;
    exp_fin = 8'h0A; m_last_tag = 8'h0A; exp_bits = 5'h09;
  endtask

  task automatic test_busy_overwrite();
    int gc0, wc0; bit ok; bit seen;
    gnt_en = 1'b1; gnt_delay = 1; rv_delay = 20;
    gc0 = gnt_count; wc0 = wr_count;
    issue(32'h05000001, 32'h7, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gnt_count != gc0) seen = 1'b1;
    end
    total_cnt++; if (!seen) $display("FAIL busy_first_gnt got=0 exp=1"); else pass_cnt++;
    issue(32'h06000002, 32'h8, 32'hCAFEF00D);
    repeat (3) @(negedge clk);
    issue(32'h07000001, 32'h9, 32'h0);
    wait_done(8'h07, 200, ok);
    total_cnt++; if (!ok) $display("FAIL busy_done got=%0d exp=1", ok); else pass_cnt++;
    total_cnt++; if (gnt_count - gc0 != 2) $display("FAIL busy_txn_count got=%0d exp=2", gnt_count - gc0); else pass_cnt++;
    total_cnt++; if (wr_count != wc0) $display("FAIL busy_lost_write got=%0d exp=%0d", wr_count, wc0); else pass_cnt++;
    total_cnt++; if (mem_status !== 32'h07000401) $display("FAIL busy_status got=%h exp=%h", mem_status, 32'h07000401); else pass_cnt++;
    total_cnt++; if (mem_data_read !== model_mem[9]) $display("FAIL busy_rdata got=%h exp=%h", mem_data_read, model_mem[9]); else pass_cnt++;
    exp_fin = 8'h07; m_last_tag = 8'h07; exp_count = 16'd4; exp_bits = 5'h01; exp_rdata = model_mem[9];
  endtask

  task automatic test_random();
    logic [7:0] tag; logic [1:0] op; logic [31:0] addr, data, exp_status;
    int r, gc0; bit ok, ignored, wrote;
    noise_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 15);
      if (r == 0) op = 2'b11;
      else if (r == 1) op = 2'b00;
      else op = (($urandom & 1) != 0) ? 2'b01 : 2'b10;
      if ($urandom_range(0, 11) == 0) tag = m_last_tag;
      else begin
        tag = 8'($urandom);
        while (tag == m_last_tag || tag == 8'd0) tag = 8'($urandom);
      end
      addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 1023));
      data = $urandom;
      gnt_en = 1'b1; gnt_delay = $urandom_range(0, 4); rv_delay = $urandom_range(0, 3);
      r = $urandom_range(0, 19);
      if (r == 0) gnt_en = 1'b0;
      else if (r == 1) rv_delay = -1;
      ignored = (op == 2'b00) || (tag == m_last_tag);
      wrote = 1'b0;
      if (!ignored) begin
        m_last_tag = tag;
        exp_fin = tag;
        if (op == 2'b11) exp_bits = 5'h05;
        else if (addr > 32'd1023) exp_bits = 5'h11;
        else if (!gnt_en) exp_bits = 5'h09;
        else if (op == 2'b01 && rv_delay < 0) exp_bits = 5'h09;
        else begin
          exp_bits = 5'h01;
          exp_count = exp_count + 16'd1;
          if (op == 2'b10) begin model_mem[addr[9:0]] = data; wrote = 1'b1; end
          else exp_rdata = model_mem[addr[9:0]];
        end
      end
      exp_status = {exp_fin, exp_count, 3'b000, exp_bits};
      gc0 = gnt_count;
      issue({tag, 22'($urandom), op}, addr, data);
      if (ignored) begin
        repeat (8) @(negedge clk);
        total_cnt++; if (gnt_count != gc0) $display("FAIL rnd%0d_ignored_req got=%0d exp=%0d", it, gnt_count, gc0); else pass_cnt++;
      end else begin
        wait_done(tag, 600, ok);
        total_cnt++; if (!ok) $display("FAIL rnd%0d_done got=%0d exp=1", it, ok); else pass_cnt++;
      end
      total_cnt++; if (mem_status !== exp_status) $display("FAIL rnd%0d_status got=%h exp=%h", it, mem_status, exp_status); else pass_cnt++;
      total_cnt++; if (mem_data_read !== exp_rdata) $display("FAIL rnd%0d_rdata got=%h exp=%h", it, mem_data_read, exp_rdata); else pass_cnt++;
      if (wrote) begin
        total_cnt++; if (mem_arr[addr[9:0]] !== data) $display("FAIL rnd%0d_mem got=%h exp=%h", it, mem_arr[addr[9:0]], data); else pass_cnt++;
      end
    end
    noise_en = 1'b0; gnt_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    int rc0; bit seen, ok;
    gnt_en = 1'b0;
    issue(32'h0B000001, 32'h3, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (m_req) seen = 1'b1;
    end
    total_cnt++; if (!seen) $display("FAIL mid_rst_req_seen got=0 exp=1"); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (m_req !== 1'b0) $display("FAIL mid_rst_req_drop got=%b exp=0", m_req); else pass_cnt++;
    total_cnt++; if (mem_status !== 32'h0) $display("FAIL mid_rst_status got=%h exp=0", mem_status); else pass_cnt++;
    mem_cmd = 32'h00000001;
    mem_addr = 32'h4;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    gnt_en = 1'b1; gnt_delay = 0;
    rc0 = req_cycles;
    repeat (10) @(negedge clk);
    total_cnt++; if (req_cycles != rc0) $display("FAIL tag0_ignored got=%0d exp=%0d", req_cycles, rc0); else pass_cnt++;
    total_cnt++; if (mem_status !== 32'h0) $display("FAIL tag0_status got=%h exp=0", mem_status); else pass_cnt++;
    issue(32'h01000002, 32'h6, 32'h12345678);
    wait_done(8'h01, 50, ok);
    total_cnt++; if (!ok) $display("FAIL post_rst_done got=%0d exp=1", ok); else pass_cnt++;
    total_cnt++; if (mem_status !== 32'h01000101) $display("FAIL post_rst_status got=%h exp=%h", mem_status, 32'h01000101); else pass_cnt++;
    total_cnt++; if (mem_arr[6] !== 32'h12345678) $display("FAIL post_rst_mem got=%h exp=12345678", mem_arr[6]); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = $urandom;
      model_mem[i] = mem_arr[i];
    end
    test_reset();
    test_write_read();
    test_same_tag();
    test_errors();
    test_timeout();
    test_busy_overwrite();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // global time bound
  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sw_mem_cmd_ctrl.md
Name: sw_mem_cmd_ctrl

Overview:
- Sequences software-issued memory accesses into a request/grant memory port.
- Sits directly downstream of the user datapath's generic register block:
  - consumes the software registers mem_cmd, mem_addr and mem_data_write;
  - produces the hardware registers mem_data_read and mem_status.
- The memory side connects to the pipeline processor's shared data-memory port.
- Converts static register values into single, tagged, timed-out memory transactions.

Parameters:
- ADDR_WIDTH, 10, memory word-address width.
- DATA_WIDTH, 32, memory data width (must be 32; matches CPCI register width).
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ or WAIT_RD before abort (8-bit counter, range 1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mem_cmd  in  32  sw reg; [1:0] op (00 none, 01 read, 10 write, 11 reserved); [31:24] tag; other bits ignored.
- mem_addr  in  32  sw reg; word address.
- mem_data_write  in  32  sw reg; write data.
- mem_data_read  out  32  hw reg; data from the last successful read.
- mem_status  out  32  hw reg; [31:24] last finished tag, [23:8] completion count, [4] addr error, [3] timeout, [2] bad op, [1] busy, [0] done.
- m_req  out  1  memory request.
- m_we  out  1  1 = write, 0 = read; valid while m_req=1.
- m_addr  out  ADDR_WIDTH  memory address.
- m_wdata  out  32  memory write data.
- m_gnt  in  1  request accepted this cycle.
- m_rvalid  in  1  read data valid.
- m_rdata  in  32  read data.

Behaviour:
- Reset (async, reset=0):
  - state IDLE; all outputs 0, including m_req/m_we/m_addr/m_wdata and the whole of mem_status;
  - internal last_tag=0, timeout counter=0.
  - Reset asserted mid-transaction drops m_req immediately; the transaction is abandoned with no status update.
- New-command rule:
  - Evaluated only in IDLE.
  - New when mem_cmd[31:24] != last_tag and mem_cmd[1:0] != 00.
  - Consequence: after reset, tag 0 is never new; software must start with tag != 0.
- Acceptance (IDLE, new command at edge N):
  - latch op, tag, addr, data; last_tag<=tag; clear status bits [4:0]; set busy.
  - op=11 -> bad op=1, done=1, busy=0, finished tag<=tag, stays IDLE, count unchanged.
  - mem_addr[31:ADDR_WIDTH] != 0 -> addr error=1, done=1, busy=0, finished tag<=tag, stays IDLE, no memory access.
  - otherwise -> REQ; m_req=1 from cycle N+1 (registered); m_we=(op==10); m_addr/m_wdata from latched values.
- REQ:
  - Hold m_req and all m_* outputs stable until m_gnt=1.
  - On m_gnt: m_req<=0; write -> COMPLETE; read -> WAIT_RD.
- WAIT_RD:
  - On m_rvalid: mem_data_read<=m_rdata -> COMPLETE.
  - The memory guarantees m_rvalid no earlier than the cycle after m_gnt; m_rvalid in any other state is ignored.
- COMPLETE (one cycle):
  - done=1, busy=0, finished tag<=latched tag, count<=count+1 (16-bit, wraps 0xFFFF->0x0000) -> IDLE.
  - Earliest next acceptance is the edge after COMPLETE.
- Timeout:
  - Counter clears on entry to REQ or WAIT_RD and increments each cycle in those states.
  - At TIMEOUT_CYCLES without the awaited event: timeout=1, done=1, busy=0, m_req<=0, finished tag<=tag, count unchanged, mem_data_read unchanged -> IDLE.
  - If grant/rvalid arrives in the same cycle the timeout is reached, the event wins.
- Register changes while busy: ignored. On return to IDLE the current mem_cmd is compared against last_tag, so only the latest value is executed; intermediate commands are lost by design.
- done/error bits are sticky until the next accepted command.
- mem_data_read changes only on a successful read.

Test Plan:
- Write then read: cmd=0x01000002, addr=0x5, data=0xDEADBEEF, m_gnt after 2 cycles -> one write pulse at addr 5; status=0x01000101. Then cmd=0x02000001 with m_rdata=0xDEADBEEF one cycle after gnt -> mem_data_read=0xDEADBEEF; status=0x02000201.
- Same tag rewritten: cmd=0x02000001 rewritten, or op changed to 10 with tag 0x02 -> no m_req; status unchanged.
- Errors: cmd=0x03000003 -> status=0x03000205 (bad op), no m_req. Then addr=0x400 with cmd=0x04000001 -> status bit4=1, no m_req.
- Timeout: m_gnt never asserted, TIMEOUT_CYCLES=255 -> m_req high exactly 255 cycles; status bit3=1, done=1; count unchanged; mem_data_read unchanged.
- Busy overwrite: issue tag 0x05 read; during WAIT_RD write tag 0x06 then tag 0x07 -> exactly two transactions (0x05, 0x07); final finished tag=0x07.
- Mid-transaction reset: reset=0 while m_req=1 -> m_req=0 in the same cycle; status=0. After release, cmd with tag 0 is ignored and tag 0x01 executes.
